// File: rtl/mc_control_fsm.sv
// Multicycle RV32 control FSM with sticky memory-wait timeout.
// Define ILLEGAL_TRAP_EN to trap unrecognised opcodes in a TRAP state.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_done,
  output logic       mem_timeout,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       tmo_q;
  logic       waiting;

  assign waiting = !mem_ready &&
    (state_q == S_FETCH || state_q == S_MEMREAD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWB, S_MEMWRITE,
      S_ALUWB, S_BEQ:     state_d = S_FETCH;
      S_EXECR, S_EXECI,
      S_JAL:              state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:             state_d = S_TRAP;
`endif
      default:            state_d = S_FETCH;
    endcase
  end

  // Saturating count of consecutive stalled memory cycles.
  always_comb begin
    wait_d = 8'd0;
    if (waiting)
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q;
  assign illegal_instr = ill_q;
`else
  assign illegal_instr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      tmo_q   <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (wait_d >= TMO) tmo_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (state_d == S_TRAP) ill_q <= 1'b1;
`endif
    end
  end

  assign mem_timeout = tmo_q;

  // Fetch strobes are gated by reset_n so nothing writes while held.
  always_comb begin
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    ResultSrc  = 2'b00;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite   = mem_ready & reset_n;
        PCUpdate  = mem_ready & reset_n;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
